// File: rtl/alu_share_arbiter.sv
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin time-sharing of the single EX-stage ALU between
//               the pipeline issue port (0) and the aux compare unit (1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,

    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_grant;
    logic             w_accept;
    logic             w_resp_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Port 1 wins only when it is alone, or on a tie when port 0 went last.
    always_comb begin
        w_grant     = req1_valid & ~(req0_valid & r_last_grant);
        w_accept    = (r_state == S_IDLE) & (req0_valid | req1_valid);
        w_resp_done = (r_state == S_RESP) & (r_owner ? resp1_ready : resp0_ready);
        w_next      = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)    w_next = S_ISSUE;
            S_ISSUE:                  w_next = S_RESP;
            S_RESP:  if (w_resp_done) w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= 4'b0000;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                r_alu_a      <= w_grant ? req1_a    : req0_a;
                r_alu_b      <= w_grant ? req1_b    : req0_b;
                r_alu_ctrl   <= w_grant ? req1_ctrl : req0_ctrl;
            end
            if (r_state == S_ISSUE) begin
                r_result <= alu_result;
                r_zero   <= alu_zero;
            end
        end
    end

    assign req0_ready   = w_accept & ~w_grant;
    assign req1_ready   = w_accept &  w_grant;

    // A single result register serves both ports; only the owner sees valid.
    assign resp0_valid  = (r_state == S_RESP) & ~r_owner;
    assign resp1_valid  = (r_state == S_RESP) &  r_owner;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp0_zero   = r_zero;
    assign resp1_zero   = r_zero;

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_ctrl     = r_alu_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Randomized and directed bench for alu_share_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v0, v1, rr0, rr1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [3:0]   c0, c1;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid, resp0_zero, resp1_zero;
    logic [W-1:0] resp0_result, resp1_result;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_ctrl;
    logic         alu_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_a(a0), .req0_b(b0), .req0_ctrl(c0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_a(a1), .req1_b(b1), .req1_ctrl(c1),
        .resp0_valid(resp0_valid), .resp0_ready(rr0), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
        .resp1_valid(resp1_valid), .resp1_ready(rr1), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] ctrl);
        case (ctrl)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = (alu_result == '0);

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which port holds the ALU and in which phase
    // (0 free, 1 computing, 2 holding result), plus the fairness pointer.
    int           m_busy;
    bit           m_owner, m_last, acc0, acc1;
    logic [W-1:0] m_a, m_b, m_res;
    logic [3:0]   m_ctrl;
    bit           m_zero;
    int           cyc = 0;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1;
        m_a = '0; m_b = '0; m_ctrl = 4'b0000; m_res = '0; m_zero = 0;
        acc0 = 0; acc1 = 0;
    endtask

    task automatic step();
        bit e_r0, e_r1;
        @(negedge clk);
        e_r0 = (m_busy == 0) && v0 && (!v1 || m_last);
        e_r1 = (m_busy == 0) && v1 && (!v0 || !m_last);
        check("req0_ready", W'(req0_ready), W'(e_r0));
        check("req1_ready", W'(req1_ready), W'(e_r1));
        check("resp0_valid", W'(resp0_valid), W'(m_busy == 2 && !m_owner));
        check("resp1_valid", W'(resp1_valid), W'(m_busy == 2 && m_owner));
        if (m_busy == 2) begin
            check("resp_result", m_owner ? resp1_result : resp0_result, m_res);
            check("resp_zero", W'(m_owner ? resp1_zero : resp0_zero), W'(m_zero));
        end
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_ctrl", W'(alu_ctrl), W'(m_ctrl));
        @(posedge clk);
        cyc++;
        acc0 = 0; acc1 = 0;
        if (m_busy == 2) begin
            if (m_owner ? rr1 : rr0) m_busy = 0;
        end else if (m_busy == 1) begin
            m_res  = alu_fn(m_a, m_b, m_ctrl);
            m_zero = (m_res == '0);
            m_busy = 2;
        end else if (e_r0) begin
            m_owner = 0; m_last = 0; m_a = a0; m_b = b0; m_ctrl = c0; m_busy = 1; acc0 = 1;
        end else if (e_r1) begin
            m_owner = 1; m_last = 1; m_a = a1; m_b = b1; m_ctrl = c1; m_busy = 1; acc1 = 1;
        end
        #1;
    endtask

    function automatic logic [3:0] pick_ctrl();
        case ($urandom_range(0, 4))
            0: return 4'b0010;
            1: return 4'b0110;
            2: return 4'b0000;
            3: return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic new_req0(input bit valid);
        v0 = valid; a0 = $urandom; c0 = pick_ctrl();
        b0 = ($urandom_range(0, 3) == 0) ? a0 : W'($urandom);
    endtask

    task automatic new_req1(input bit valid);
        v1 = valid; a1 = $urandom; c1 = pick_ctrl();
        b1 = ($urandom_range(0, 3) == 0) ? a1 : W'($urandom);
    endtask

    task automatic do_reset();
        v0 = 0; v1 = 0;
        rst_n = 0;
        #1;
        model_reset();
        check("rst_req0_ready", W'(req0_ready), '0);
        check("rst_req1_ready", W'(req1_ready), '0);
        check("rst_resp0_valid", W'(resp0_valid), '0);
        check("rst_resp1_valid", W'(resp1_valid), '0);
        check("rst_resp0_result", resp0_result, '0);
        check("rst_resp1_result", resp1_result, '0);
        check("rst_resp0_zero", W'(resp0_zero), '0);
        check("rst_resp1_zero", W'(resp1_zero), '0);
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_b", alu_b, '0);
        check("rst_alu_ctrl", W'(alu_ctrl), '0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc_port[$];
        int acc_cyc[$];
        logic [W-1:0] held;

        rst_n = 1; v0 = 0; v1 = 0; rr0 = 1; rr1 = 1;
        a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
        #2;
        do_reset();

        // Single op: 5 + 3
        v0 = 1; a0 = 5; b0 = 3; c0 = 4'b0010;
        step();
        check("single_accept", W'(acc0), 1);
        v0 = 0;
        step();
        check("single_valid", W'(resp0_valid), 1);
        check("single_result", resp0_result, 8);
        check("single_zero", W'(resp0_zero), 0);
        step();

        // Tie straight after reset goes to port 0
        do_reset();
        v0 = 1; a0 = 7;    b0 = 7;    c0 = 4'b0110;
        v1 = 1; a1 = 'h0F; b1 = 'hF0; c1 = 4'b0001;
        step();
        check("tie_port0_first", W'(acc0), 1);
        v0 = 0;
        step();
        check("tie_resp0_result", resp0_result, 0);
        check("tie_resp0_zero", W'(resp0_zero), 1);
        step();
        step();
        check("tie_port1_at_T3", W'(acc1), 1);
        v1 = 0;
        step();
        check("tie_resp1_result", resp1_result, 'hFF);
        step();

        // Continuous dual requests alternate, one accept per 3 cycles
        do_reset();
        new_req0(1); new_req1(1);
        for (int i = 0; i < 16; i++) begin
            step();
            if (acc0) begin acc_port.push_back(0); acc_cyc.push_back(cyc); new_req0(1); end
            if (acc1) begin acc_port.push_back(1); acc_cyc.push_back(cyc); new_req1(1); end
        end
        check("alt_count", W'(acc_port.size()), 6);
        for (int i = 0; i < acc_port.size() && i < 6; i++) begin
            check("alt_port", W'(acc_port[i]), W'(i % 2));
            if (i > 0) check("alt_spacing", W'(acc_cyc[i] - acc_cyc[i-1]), 3);
        end

        // Back-pressure on port 1 while port 0 waits
        do_reset();
        v1 = 1; a1 = 'h1234; b1 = 'h1; c1 = 4'b0110;
        step();
        check("bp_port1_accept", W'(acc1), 1);
        v1 = 0; rr1 = 0;
        v0 = 1; a0 = 9; b0 = 9; c0 = 4'b0110;
        step();
        held = resp1_result;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_result_stable", resp1_result, held);
            check("bp_ready0_low", W'(req0_ready), 0);
        end
        rr1 = 1;
        step();
        step();
        check("bp_req0_next", W'(acc0), 1);
        v0 = 0;
        step();
        step();

        // Reset while ISSUE is in progress drops the transaction
        v0 = 1; a0 = 'h55; b0 = 'h22; c0 = 4'b0001;
        step();
        check("mid_accept", W'(acc0), 1);
        do_reset();
        for (int i = 0; i < 3; i++) step();
        v0 = 1; a0 = 1; b0 = 2; c0 = 4'b0010;
        v1 = 1; a1 = 3; b1 = 4; c1 = 4'b0010;
        step();
        check("mid_tie_port0", W'(acc0), 1);
        v0 = 0;
        step(); step(); step();
        v1 = 0;
        step(); step();

        // AND producing zero on port 1
        v1 = 1; a1 = 'hF0; b1 = 'h0F; c1 = 4'b0000;
        step();
        check("and_accept", W'(acc1), 1);
        v1 = 0;
        step();
        check("and_result", resp1_result, 0);
        check("and_zero", W'(resp1_zero), 1);
        step();

        // Randomized traffic with random response back-pressure
        for (int i = 0; i < 3000; i++) begin
            if (!v0 || acc0) new_req0($urandom_range(0, 2) != 0);
            if (!v1 || acc1) new_req1($urandom_range(0, 2) != 0);
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            step();
        end
        if (acc0) v0 = 0;
        if (acc1) v1 = 0;
        rr0 = 1; rr1 = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (acc0) v0 = 0;
            if (acc1) v1 = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequential arbiter that time-shares the single EX-stage ALU between two requesters: port 0, the pipeline EX issue, and port 1, the auxiliary address/branch-compare unit. It grants one request at a time using round-robin priority and latches the operands and the 4-bit ALU control code. It drives the shared ALU for one cycle, captures the result and zero flag, and holds them for the granted requester until that requester accepts them. It sits between the requesters and the ALU, whose inputs come from the ALU control decoder.

## Interface
Parameters:
- WIDTH, 32, operand/result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N=0,1) request present.
- reqN_ready  out  1  request accepted this cycle when high with reqN_valid.
- reqN_a, reqN_b  in  WIDTH  operands.
- reqN_ctrl  in  4  ALU control code: 0010 add, 0110 sub, 0000 and, 0001 or.
- respN_valid  out  1  result available for requester N.
- respN_ready  in  1  requester N consumes its result.
- respN_result  out  WIDTH  captured ALU result.
- respN_zero  out  1  captured ALU zero flag.
- alu_a, alu_b  out  WIDTH  registered operands to the shared ALU.
- alu_ctrl  out  4  registered control code to the shared ALU.
- alu_result  in  WIDTH  combinational ALU result.
- alu_zero  in  1  combinational ALU zero flag.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: grant is combinational from the valids.
  - With one valid: grant that port.
  - With both valid: grant the port NOT granted last (last_grant register).
  - reqG_ready = 1 only for the granted port, only in IDLE; the other ready = 0.
  - On handshake: latch a/b/ctrl into alu_a/alu_b/alu_ctrl, record the owner, update last_grant to G, go to ISSUE.
- ISSUE: ALU evaluates the latched operands.
  - At the clock edge, capture alu_result/alu_zero into the response register, set respG_valid, go to RESP.
- RESP: respG_valid held high, result and zero held stable until respG_ready.
  - On respG_valid & respG_ready: clear respG_valid, go to IDLE.
  - No new request is accepted in ISSUE or RESP; both readys = 0.
- respN_result/respN_zero for the non-owner port: value is don't-care; respN_valid = 0.
- Requester rules:
  - reqN_valid must not depend on reqN_ready.
  - Once asserted, valid and payload stay stable until the handshake.
  - A withdrawn request (valid dropped before ready) is legal only in cycles where ready was 0, and it is simply not granted.
- alu_a/alu_b/alu_ctrl keep their last values outside ISSUE; they are not cleared after use.
- Unknown ctrl codes are passed through unchanged; decoding belongs to the ALU.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; last_grant = 1, so port 0 wins the first tie.
  - alu_a = 0, alu_b = 0, alu_ctrl = 0000.
  - resp0_valid = resp1_valid = 0; resp results = 0, zero flags = 0.
  - An in-flight transaction is dropped, with no response.
- Latency: handshake at edge T; ISSUE during cycle T+1; respG_valid high from T+2.
- Best-case throughput is one operation per 3 cycles (respG_ready held high): accept at T, T+3, T+6, …
- Response back-pressure: RESP holds indefinitely. The other requester waits and keeps its valid asserted.
- Fairness:
  - Under continuous dual requests, grants strictly alternate 0,1,0,1,…
  - A single active requester is granted every opportunity.
- readys are combinational from state, valids and last_grant. No combinational path from alu_result to any ready.

## Test plan
- Single op: req0 a=5, b=3, ctrl=0010 → ready0 at T; alu_a=5, alu_b=3 in T+1; resp0_valid at T+2 with result=8, zero=0.
- Tie after reset: both valid at T (req0 sub 7−7, req1 or 0x0F|0xF0) → port 0 first; resp0 result=0, zero=1. Port 1 is accepted at T+3 and responds with result=0xFF.
- Alternation: both valid continuously for 6 ops → grant order 0,1,0,1,0,1; accepts at T, T+3, …, T+15.
- Back-pressure: resp1_ready low for 5 cycles, with req0 valid throughout → resp1 result stable, ready0 stays 0; req0 is granted the cycle after the resp1 handshake.
- Reset mid-op: rst_n low during ISSUE → all outputs read their reset values immediately. After release, no response appears; the next tie grants port 0.
- And/zero: req1 a=0xF0, b=0x0F, ctrl=0000 → resp1 result=0, zero=1.
